// File: rtl/pll_divgen_multi.sv
// Multi-channel fabric clock divider: phase-aligned divided clocks/enables with settle-based lock
// and a valid/ready port for runtime ratio changes. Optional start phase: PLL_DIVGEN_PHASE_EN.
module pll_divgen_multi #(
  parameter int NUM_CLKS    = 3,
  parameter int DIV_W       = 8,
  parameter int DEF_DIV     = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_sel,
  input  logic [DIV_W-1:0]    cfg_div,
`ifdef PLL_DIVGEN_PHASE_EN
  input  logic [DIV_W-1:0]    cfg_phase,
`endif
  output logic                cfg_err,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] outclk_en,
  output logic                locked
);

  localparam logic [1:0] SETTLE   = 2'd0;
  localparam logic [1:0] LOCKED   = 2'd1;
  localparam logic [1:0] RECONFIG = 2'd2;

  localparam int               SET_W       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1);
  localparam logic [3:0]       NUM_CLKS_L  = 4'(NUM_CLKS);
  localparam logic [DIV_W-1:0] DEF_DIV_L   = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);

  // FSM state register; the name is stable so external checkers can bind to it.
  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [SET_W-1:0]    settle_q;

  logic [DIV_W-1:0]    div_q    [NUM_CLKS];
  logic [DIV_W-1:0]    cnt_q    [NUM_CLKS];
  logic [DIV_W-1:0]    cnt_d    [NUM_CLKS];
  logic [DIV_W-1:0]    half_div [NUM_CLKS];
  logic [NUM_CLKS-1:0] outclk_d;
  logic [NUM_CLKS-1:0] outclk_en_d;

  logic [2:0]          pend_sel;
  logic [DIV_W-1:0]    pend_div;
`ifdef PLL_DIVGEN_PHASE_EN
  logic [DIV_W-1:0]    phase_q  [NUM_CLKS];
  logic [DIV_W-1:0]    pend_phase;
`endif

  logic xfer;
  logic req_ok;
  logic go_lock;
  logic run;

  // Handshake: a request transfers on the rising edge where cfg_valid && cfg_ready; cfg_sel,
  // cfg_div (and cfg_phase) are sampled only then. cfg_ready is high only while locked, and the
  // requester holds cfg_valid and its payload stable until the transfer edge.
  assign cfg_ready = locked;
  assign xfer      = cfg_valid && cfg_ready;

`ifdef PLL_DIVGEN_PHASE_EN
  assign req_ok = ({1'b0, cfg_sel} < NUM_CLKS_L) && (cfg_div != '0) && (cfg_phase < cfg_div);
`else
  assign req_ok = ({1'b0, cfg_sel} < NUM_CLKS_L) && (cfg_div != '0);
`endif

  assign go_lock = (state_q == SETTLE) && (settle_q == SETTLE_LAST);
  // Channels keep running only while locked and not being torn down by an accepted request.
  assign run     = go_lock || ((state_q == LOCKED) && !(xfer && req_ok));

  always_comb begin
    state_d = state_q;
    case (state_q)
      SETTLE:   if (settle_q == SETTLE_LAST) state_d = LOCKED;
      LOCKED:   if (xfer && req_ok) state_d = RECONFIG;
      RECONFIG: state_d = SETTLE;
      default:  state_d = SETTLE;
    endcase
  end

  // Outputs are computed from the next counter value so the registered outputs line up with
  // the counter in the same cycle, including the first locked cycle.
  always_comb begin
    outclk_d    = '0;
    outclk_en_d = '0;
    for (int i = 0; i < NUM_CLKS; i++) begin
      cnt_d[i]    = '0;
      half_div[i] = (div_q[i] >> 1) + DIV_W'(div_q[i][0]);
      if (go_lock) begin
`ifdef PLL_DIVGEN_PHASE_EN
        cnt_d[i] = phase_q[i];
`else
        cnt_d[i] = '0;
`endif
      end else if (run) begin
        cnt_d[i] = (cnt_q[i] == div_q[i] - ONE) ? '0 : cnt_q[i] + ONE;
      end
      outclk_d[i]    = run && (cnt_d[i] < half_div[i]);
      outclk_en_d[i] = run && (cnt_d[i] == div_q[i] - ONE);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SETTLE;
      settle_q  <= '0;
      locked    <= 1'b0;
      cfg_err   <= 1'b0;
      outclk    <= '0;
      outclk_en <= '0;
      pend_sel  <= '0;
      pend_div  <= DEF_DIV_L;
`ifdef PLL_DIVGEN_PHASE_EN
      pend_phase <= '0;
`endif
      for (int i = 0; i < NUM_CLKS; i++) begin
        div_q[i] <= DEF_DIV_L;
        cnt_q[i] <= '0;
`ifdef PLL_DIVGEN_PHASE_EN
        phase_q[i] <= '0;
`endif
      end
    end else begin
      state_q   <= state_d;
      settle_q  <= ((state_q == SETTLE) && !go_lock) ? settle_q + SET_ONE : '0;
      locked    <= (state_d == LOCKED);
      cfg_err   <= xfer && !req_ok;
      outclk    <= outclk_d;
      outclk_en <= outclk_en_d;
      if (xfer && req_ok) begin
        pend_sel <= cfg_sel;
        pend_div <= cfg_div;
`ifdef PLL_DIVGEN_PHASE_EN
        pend_phase <= cfg_phase;
`endif
      end
      for (int i = 0; i < NUM_CLKS; i++) begin
        cnt_q[i] <= cnt_d[i];
        // The accepted ratio lands during RECONFIG; every channel then resettles together.
        if ((state_q == RECONFIG) && (pend_sel == 3'(i))) begin
          div_q[i] <= pend_div;
`ifdef PLL_DIVGEN_PHASE_EN
          phase_q[i] <= pend_phase;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pll_divgen_multi.sv
// Bench for pll_divgen_multi: arithmetic reference model feeding an expected queue, a per-cycle
// comparator, and hand-computed directed checks.
module tb_pll_divgen_multi;

  localparam int NUM_CLKS    = 3;
  localparam int DIV_W       = 8;
  localparam int DEF_DIV     = 2;
  localparam int LOCK_CYCLES = 16;
  localparam int W           = 3 + 2 * NUM_CLKS;

  logic                refclk    = 1'b0;
  logic                rst_n     = 1'b0;
  logic                cfg_valid = 1'b0;
  logic [2:0]          cfg_sel   = '0;
  logic [DIV_W-1:0]    cfg_div   = '0;
`ifdef PLL_DIVGEN_PHASE_EN
  logic [DIV_W-1:0]    cfg_phase = '0;
`endif
  logic                cfg_ready;
  logic                cfg_err;
  logic                locked;
  logic [NUM_CLKS-1:0] outclk;
  logic [NUM_CLKS-1:0] outclk_en;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 refclk = ~refclk;

  pll_divgen_multi #(
    .NUM_CLKS(NUM_CLKS), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
`ifdef PLL_DIVGEN_PHASE_EN
    .cfg_phase (cfg_phase),
`endif
    .cfg_err   (cfg_err),
    .outclk    (outclk),
    .outclk_en (outclk_en),
    .locked    (locked)
  );

  // ---------------- reference model ----------------
  // m_e: rising edges since reset release; m_lock_at: edge after which locked is high;
  // channel i output at locked cycle k is derived from (k + phase) mod D.
  int m_e;
  int m_lock_at;
  int m_err_at;
  int m_div [NUM_CLKS];
  int m_ph  [NUM_CLKS];
  bit m_rdy;
  bit m_ok;
  logic [W-1:0] exp_q [$];

  function automatic logic [W-1:0] model_vec();
    logic                lk;
    logic [NUM_CLKS-1:0] oc;
    logic [NUM_CLKS-1:0] en;
    int                  pos;
    lk = (m_e >= m_lock_at);
    oc = '0;
    en = '0;
    if (lk) begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        pos   = ((m_e - m_lock_at) + m_ph[i]) % m_div[i];
        oc[i] = (pos < (m_div[i] + 1) / 2);
        en[i] = (pos == m_div[i] - 1);
      end
    end
    return {lk, lk, (m_err_at == m_e), oc, en};
  endfunction

  always @(negedge rst_n) exp_q.delete();

  always @(posedge refclk) begin
    if (!rst_n) begin
      m_e       = 0;
      m_lock_at = LOCK_CYCLES;
      m_err_at  = -1;
      for (int i = 0; i < NUM_CLKS; i++) begin
        m_div[i] = DEF_DIV;
        m_ph[i]  = 0;
      end
      exp_q.push_back('0);
    end else begin
      m_rdy = (m_e >= m_lock_at);
      m_e   = m_e + 1;
      if (cfg_valid && m_rdy) begin
        m_ok = (int'(cfg_sel) < NUM_CLKS) && (cfg_div != 0);
`ifdef PLL_DIVGEN_PHASE_EN
        m_ok = m_ok && (cfg_phase < cfg_div);
`endif
        if (m_ok) begin
          m_div[cfg_sel] = int'(cfg_div);
`ifdef PLL_DIVGEN_PHASE_EN
          m_ph[cfg_sel]  = int'(cfg_phase);
`endif
          m_lock_at = m_e + 1 + LOCK_CYCLES;
        end else begin
          m_err_at = m_e;
        end
      end
      exp_q.push_back(model_vec());
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge refclk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {locked, cfg_ready, cfg_err, outclk, outclk_en};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t {locked,ready,err,outclk,en} got=%b expected=%b",
                 $time, act_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge right after the transfer edge.
  task automatic cfg_write(input logic [2:0] sel, input logic [DIV_W-1:0] div,
                           input logic [DIV_W-1:0] ph);
    bit done;
    done      = 1'b0;
    cfg_sel   = sel;
    cfg_div   = div;
`ifdef PLL_DIVGEN_PHASE_EN
    cfg_phase = ph;
`endif
    cfg_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      if (cfg_ready === 1'b1) begin
        @(posedge refclk);
        done = 1'b1;
      end
      @(negedge refclk);
    end
    cfg_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL cfg_timeout: cfg_ready never high for sel=%0d div=%0d ph=%0d", sel, div, ph);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    tick(3);
    chk("reset_locked", locked, 0);
    chk("reset_outclk", outclk, 0);
    chk("reset_ready", cfg_ready, 0);
    rst_n = 1'b1;

    // Initial lock with DEF_DIV=2 on all channels
    tick(15);
    chk("settle_edge15_locked", locked, 0);
    tick(1);
    chk("lock_edge16", locked, 1);
    chk("k0_outclk", outclk, 3'b111);
    chk("k0_en", outclk_en, 3'b000);
    tick(1);
    chk("k1_outclk", outclk, 3'b000);
    chk("k1_en", outclk_en, 3'b111);

    // ch1 -> divide by 3, all channels resync
    cfg_write(3'd1, 8'd3, 8'd0);
    chk("reconf_locked_low", locked, 0);
    chk("reconf_outclk_low", outclk, 0);
    tick(16);
    chk("relock_t16_low", locked, 0);
    tick(1);
    chk("relock_t17_high", locked, 1);
    chk("d3_k0_outclk", outclk, 3'b111);
    chk("d3_k0_en", outclk_en, 3'b000);
    tick(1);
    chk("d3_k1_outclk", outclk, 3'b010);
    chk("d3_k1_en", outclk_en, 3'b101);
    tick(1);
    chk("d3_k2_outclk", outclk, 3'b101);
    chk("d3_k2_en", outclk_en, 3'b010);

    // Out-of-range channel: rejected, channels undisturbed (k3)
    cfg_write(3'd5, 8'd4, 8'd0);
    chk("badsel_err", cfg_err, 1);
    chk("badsel_locked", locked, 1);
    chk("badsel_k3_outclk", outclk, 3'b010);
    chk("badsel_k3_en", outclk_en, 3'b101);
    tick(1);
    chk("badsel_err_pulse_end", cfg_err, 0);

    // Zero divide rejected, then divide by 1
    cfg_write(3'd0, 8'd0, 8'd0);
    chk("div0_err", cfg_err, 1);
    chk("div0_locked", locked, 1);
    tick(1);
    chk("div0_err_end", cfg_err, 0);
    cfg_write(3'd0, 8'd1, 8'd0);
    chk("div1_locked_low", locked, 0);
    tick(17);
    chk("div1_relock", locked, 1);
    for (int k = 0; k < 4; k++) begin
      chk("div1_outclk0", outclk[0], 1);
      chk("div1_en0", outclk_en[0], 1);
      tick(1);
    end

    // Max ratio on ch2; the second write is held while not ready and lands after relock
    cfg_write(3'd2, 8'd255, 8'd0);
    cfg_write(3'd1, 8'd2, 8'd0);
    tick(17);
    chk("d255_relock", locked, 1);
    tick(127);
    chk("d255_k127_high", outclk[2], 1);
    tick(1);
    chk("d255_k128_low", outclk[2], 0);
    tick(126);
    chk("d255_k254_en", outclk_en[2], 1);
    tick(1);
    chk("d255_k255_wrap_en", outclk_en[2], 0);
    chk("d255_k255_wrap_clk", outclk[2], 1);

    // Reset mid-settle after a reconfig: pending div discarded
    cfg_write(3'd0, 8'd7, 8'd0);
    tick(9);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_locked", locked, 0);
    chk("midrst_outclk", outclk, 0);
    chk("midrst_en", outclk_en, 0);
    chk("midrst_err", cfg_err, 0);
    tick(2);
    rst_n = 1'b1;
    tick(15);
    chk("rst2_edge15", locked, 0);
    tick(1);
    chk("rst2_edge16", locked, 1);
    chk("rst2_k0_outclk", outclk, 3'b111);
    tick(1);
    chk("rst2_k1_outclk0", outclk[0], 0);
    chk("rst2_k1_en0", outclk_en[0], 1);

`ifdef PLL_DIVGEN_PHASE_EN
    cfg_write(3'd2, 8'd4, 8'd1);
    tick(17);
    chk("ph_relock", locked, 1);
    chk("ph_k0_outclk2", outclk[2], 1);
    chk("ph_k0_en2", outclk_en[2], 0);
    tick(2);
    chk("ph_k2_en2", outclk_en[2], 1);
    tick(4);
    chk("ph_k6_en2", outclk_en[2], 1);
    cfg_write(3'd2, 8'd4, 8'd4);
    chk("ph_bad_err", cfg_err, 1);
    chk("ph_bad_locked", locked, 1);
`endif

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
